wb_rr_arb_wdt: RTL

- Round-robin Wishbone bus arbiter with a built-in bus watchdog, for the shared-bus interconnect.
- Takes one CYC request per master and drives a one-hot grant that selects the master onto the shared bus.
- Monitors the shared STB/ACK pair and issues a one-cycle error termination when a slave fails to respond within a programmable bound. This keeps a dead slave from stalling the CPU forever.
- Replaces the fixed grant logic feeding the interconnect's master mux and ACK gating.

---
 rtl/wb_rr_arb_wdt.sv | 105 ++++++++++
 1 files changed

// File: rtl/wb_rr_arb_wdt.sv
// Round-robin Wishbone bus arbiter with a bus watchdog.
// Grants one master at a time and terminates stalled cycles with ERR.
module wb_rr_arb_wdt #(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 bus_stb_i,
    input  logic                 bus_ack_i,
    output logic [N_MASTERS-1:0] gnt,
    output logic                 err_o,
    output logic [7:0]           to_count_o,
    output logic [2:0]           to_master_o
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [IW-1:0]   LAST_RST = IW'(N_MASTERS - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [N_MASTERS-1:0] ONE = N_MASTERS'(1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t         state;
    logic [IW-1:0]  last;
    logic [IW-1:0]  pick;
    logic [IW-1:0]  jj;
    int             j;
    logic           any_req;
    logic           release_c;
    logic           wd_busy;
    logic           timeout;
    logic [TO_W-1:0] wd_cnt;

    // Scan downward so the requester closest after last wins.
    always_comb begin
        pick = last;
        j    = 0;
        jj   = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            j = int'(last) + k;
            if (j >= N_MASTERS) j = j - N_MASTERS;
            jj = j[IW-1:0];
            if (req[jj]) pick = jj;
        end
    end

    assign any_req   = |req;
    assign release_c = !req[last];
    assign wd_busy   = (state == OWNED) && bus_stb_i && !bus_ack_i;
    // No error while the owner is letting go, so err_o never lands in IDLE.
    assign timeout   = wd_busy && !err_o && !release_c && (wd_cnt == TO_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state       <= IDLE;
            gnt         <= '0;
            last        <= LAST_RST;
            err_o       <= 1'b0;
            wd_cnt      <= '0;
            to_count_o  <= '0;
            to_master_o <= '0;
        end else begin
            err_o <= timeout;
            if (timeout) begin
                to_master_o <= 3'(last);
                if (to_count_o != 8'hFF) to_count_o <= to_count_o + 8'd1;
            end
            if (timeout || err_o || !wd_busy || release_c)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + TO_W'(1);
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= OWNED;
                        gnt   <= ONE << pick;
                        last  <= pick;
                    end
                end
                OWNED: begin
                    if (release_c) begin
                        if (any_req) begin
                            gnt  <= ONE << pick;
                            last <= pick;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule
